// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with frame-synchronous input snapshot,
// leading-zero suppression and PWM brightness with a dead-time cycle per slot.
module seg_scan_driver #(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 1000,
  parameter int CAT_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   data,
  input  logic [NUM_DIGITS-1:0]     dp,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic                      lz_blank,
  input  logic [3:0]                brightness,
  output logic [NUM_DIGITS-1:0]     cat,
  output logic [7:0]                seg,
  output logic                      frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int OW = $clog2(16 * SCAN_DIV);
  localparam logic CAT_POL = (CAT_ACTIVE_LOW != 0);
  localparam logic SEG_POL = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] CAT_OFF = {NUM_DIGITS{CAT_POL}};
  localparam logic [7:0]            SEG_OFF = {8{SEG_POL}};

  logic [CW-1:0]            cnt_q, cnt_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]  data_sh_q, data_sh_d;
  logic [NUM_DIGITS-1:0]    dp_sh_q, dp_sh_d;
  logic [NUM_DIGITS-1:0]    en_sh_q, en_sh_d;
  logic                     lz_sh_q, lz_sh_d;
  logic [3:0]               br_sh_q, br_sh_d;
  logic [NUM_DIGITS-1:0]    cat_q, cat_d;
  logic [7:0]               seg_q, seg_d;
  logic                     ft_q, ft_d;

  logic                     last_cnt_s;
  logic                     last_idx_s;
  logic                     snap_s;
  logic [OW-1:0]            on_time_s;
  logic [3:0]               nib_s;
  logic                     blank_s;
  logic                     lit_s;
  logic [NUM_DIGITS-1:0]    sel_s;
  logic [7:0]               seg_raw_s;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] abcdefg;
    case (nib)
      4'h0:    abcdefg = 7'b1111110;
      4'h1:    abcdefg = 7'b0110000;
      4'h2:    abcdefg = 7'b1101101;
      4'h3:    abcdefg = 7'b1111001;
      4'h4:    abcdefg = 7'b0110011;
      4'h5:    abcdefg = 7'b1011011;
      4'h6:    abcdefg = 7'b1011111;
      4'h7:    abcdefg = 7'b1110000;
      4'h8:    abcdefg = 7'b1111111;
      4'h9:    abcdefg = 7'b1111011;
      4'hA:    abcdefg = 7'b1110111;
      4'hB:    abcdefg = 7'b0011111;
      4'hC:    abcdefg = 7'b1001110;
      4'hD:    abcdefg = 7'b0111101;
      4'hE:    abcdefg = 7'b1001111;
      4'hF:    abcdefg = 7'b1000111;
      default: abcdefg = 7'b0000000;
    endcase
    return abcdefg;
  endfunction

  // Scan counters and frame-start snapshot of all display inputs
  always_comb begin
    last_cnt_s = (cnt_q == CW'(SCAN_DIV - 1));
    last_idx_s = (idx_q == IW'(NUM_DIGITS - 1));
    snap_s     = (cnt_q == {CW{1'b0}}) && (idx_q == {IW{1'b0}});
    cnt_d      = last_cnt_s ? {CW{1'b0}} : cnt_q + CW'(1);
    if (last_cnt_s) begin
      idx_d = last_idx_s ? {IW{1'b0}} : idx_q + IW'(1);
    end else begin
      idx_d = idx_q;
    end
    if (snap_s) begin
      data_sh_d = data;
      dp_sh_d   = dp;
      en_sh_d   = digit_en;
      lz_sh_d   = lz_blank;
      br_sh_d   = brightness;
    end else begin
      data_sh_d = data_sh_q;
      dp_sh_d   = dp_sh_q;
      en_sh_d   = en_sh_q;
      lz_sh_d   = lz_sh_q;
      br_sh_d   = br_sh_q;
    end
  end

  // Pin values for the next edge, derived from the current slot and shadows
  always_comb begin
    on_time_s = ((OW'(br_sh_q) + OW'(1)) * OW'(SCAN_DIV - 1)) >> 4;
    nib_s     = data_sh_q[{idx_q, 2'b00} +: 4];
    // A digit is leading-zero when it and every more significant nibble are 0
    blank_s   = lz_sh_q && (idx_q != {IW{1'b0}}) &&
                ((data_sh_q >> {idx_q, 2'b00}) == {(4*NUM_DIGITS){1'b0}});
    lit_s     = (cnt_q != {CW{1'b0}}) && (OW'(cnt_q) <= on_time_s) && en_sh_q[idx_q];
    sel_s     = {NUM_DIGITS{1'b0}};
    sel_s[idx_q] = 1'b1;
    seg_raw_s = {(blank_s ? 7'b0000000 : seg_decode(nib_s)), dp_sh_q[idx_q]};
    if (lit_s) begin
      cat_d = sel_s ^ CAT_OFF;
      seg_d = seg_raw_s ^ SEG_OFF;
    end else begin
      cat_d = CAT_OFF;
      seg_d = SEG_OFF;
    end
    ft_d = last_cnt_s && last_idx_s;
  end

  // State and registered pin outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= {CW{1'b0}};
      idx_q     <= {IW{1'b0}};
      data_sh_q <= {(4*NUM_DIGITS){1'b0}};
      dp_sh_q   <= {NUM_DIGITS{1'b0}};
      en_sh_q   <= {NUM_DIGITS{1'b0}};
      lz_sh_q   <= 1'b0;
      br_sh_q   <= 4'h0;
      cat_q     <= CAT_OFF;
      seg_q     <= SEG_OFF;
      ft_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_sh_q <= data_sh_d;
      dp_sh_q   <= dp_sh_d;
      en_sh_q   <= en_sh_d;
      lz_sh_q   <= lz_sh_d;
      br_sh_q   <= br_sh_d;
      cat_q     <= cat_d;
      seg_q     <= seg_d;
      ft_q      <= ft_d;
    end
  end

  assign cat        = cat_q;
  assign seg        = seg_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: an edge-count based reference model checked every
// cycle, directed scenarios with literal pins, then randomized inputs.
module tb_seg_scan_driver;
  localparam int N  = 4;
  localparam int SD = 16;
  localparam int P  = N * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  digit_en = 4'h0;
  logic        lz_blank = 1'b0;
  logic [3:0]  brightness = 4'h0;
  logic [3:0]  cat;
  logic [7:0]  seg;
  logic        frame_tick;

  seg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .CAT_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .dp(dp), .digit_en(digit_en),
    .lz_blank(lz_blank), .brightness(brightness), .cat(cat), .seg(seg),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int k = 0;
  logic [6:0]  dec_tbl [16];
  logic [15:0] sh_data;
  logic [3:0]  sh_dp, sh_en, sh_br;
  logic        sh_lz;
  logic [3:0]  exp_cat;
  logic [7:0]  exp_seg;
  logic        exp_ft;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s k=%0d got %h want %h", name, k, act, want);
  endtask

  task automatic model_reset();
    k = 0;
    sh_data = 16'h0; sh_dp = 4'h0; sh_en = 4'h0; sh_br = 4'h0; sh_lz = 1'b0;
    exp_cat = 4'hF; exp_seg = 8'hFF; exp_ft = 1'b0;
  endtask

  // Position in the frame is just the number of edges seen since release
  task automatic model_edge();
    int pos, di, c, on;
    logic lit, blank;
    logic [3:0] nib;
    pos = k % P;
    di  = pos / SD;
    c   = pos % SD;
    on  = ((int'(sh_br) + 1) * (SD - 1)) / 16;
    lit = (c != 0) && (c <= on) && sh_en[di];
    nib = 4'(sh_data >> (4 * di));
    blank = sh_lz && (di > 0) && ((sh_data >> (4 * di)) == 16'h0);
    exp_cat = lit ? ~(4'b0001 << di) : 4'hF;
    exp_seg = lit ? ~{(blank ? 7'b0000000 : dec_tbl[nib]), sh_dp[di]} : 8'hFF;
    exp_ft  = (pos == P - 1);
    if (pos == 0) begin
      sh_data = data; sh_dp = dp; sh_en = digit_en; sh_lz = lz_blank; sh_br = brightness;
    end
    k++;
  endtask

  task automatic compare();
    check("cat", {4'h0, cat}, {4'h0, exp_cat});
    check("seg", seg, exp_seg);
    check("frame_tick", {7'h0, frame_tick}, {7'h0, exp_ft});
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  task automatic pin_dark(input string name);
    check({name, "_cat"}, {4'h0, cat}, 8'h0F);
    check({name, "_seg"}, seg, 8'hFF);
    check({name, "_ft"}, {7'h0, frame_tick}, 8'h00);
  endtask

  // Called at a negedge; leaves reset released at a negedge, k == 0
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    pin_dark("reset");
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    dec_tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    model_reset();
    @(negedge clk);

    // First frame, full brightness
    brightness = 4'hF; data = 16'h1234; digit_en = 4'hF; dp = 4'h0; lz_blank = 1'b0;
    do_reset();
    run_to(1);  check("edge1_dark", {4'h0, cat}, 8'h0F);
    run_to(2);  check("d0_cat", {4'h0, cat}, 8'h0E); check("d0_seg4", seg, 8'b10011001);
    run_to(16); check("d0_last", {4'h0, cat}, 8'h0E);
    run_to(17); check("dead_cat", {4'h0, cat}, 8'h0F); check("dead_seg", seg, 8'hFF);
    run_to(18); check("d1_cat", {4'h0, cat}, 8'h0D); check("d1_seg3", seg, 8'b00001101);
    run_to(32); check("d1_last", {4'h0, cat}, 8'h0D);
    run_to(63); check("ft_63", {7'h0, frame_tick}, 8'h00);
    run_to(64); check("ft_64", {7'h0, frame_tick}, 8'h01);
    run_to(65); check("ft_65", {7'h0, frame_tick}, 8'h00);
    run_to(130);

    // Brightness 0 never lights; brightness 7 lights cnt 1..7
    brightness = 4'h0;
    do_reset();
    run_to(2);  check("br0_dark", {4'h0, cat}, 8'h0F);
    run_to(70);
    brightness = 4'h7;
    do_reset();
    run_to(8);  check("br7_on", {4'h0, cat}, 8'h0E);
    run_to(9);  check("br7_off", {4'h0, cat}, 8'h0F);
    run_to(70);

    // Leading-zero suppression
    brightness = 4'hF; data = 16'h0050; lz_blank = 1'b1; dp = 4'b1000;
    do_reset();
    run_to(2);  check("lz_d0_seg", seg, 8'b00000011);
    run_to(18); check("lz_d1_seg", seg, 8'b01001001);
    run_to(34); check("lz_d2_cat", {4'h0, cat}, 8'h0B); check("lz_d2_seg", seg, 8'hFF);
    run_to(50); check("lz_d3_cat", {4'h0, cat}, 8'h07); check("lz_d3_seg", seg, 8'hFE);
    run_to(70);

    // Tearing: mid-frame change waits for the next frame
    data = 16'h1111; lz_blank = 1'b0; dp = 4'h0;
    do_reset();
    run_to(30); data = 16'h2222;
    run_to(34); check("tear_d2", seg, 8'b10011111);
    run_to(50); check("tear_d3", seg, 8'b10011111);
    run_to(66); check("new_d0_cat", {4'h0, cat}, 8'h0E); check("new_d0_seg", seg, 8'b00100101);
    run_to(100);

    // Partial enable and an asynchronous reset pulse mid-frame
    digit_en = 4'b0101; data = 16'($urandom);
    do_reset();
    run_to(18); check("en_d1_off", {4'h0, cat}, 8'h0F);
    run_to(100);
    @(posedge clk);
    model_edge();
    #1 rst_n = 1'b0;
    #1 pin_dark("async");
    model_reset();
    @(negedge clk);
    compare();
    rst_n = 1'b1;
    run_to(2);  check("relit_d0", {4'h0, cat}, 8'h0E);
    run_to(100);

    // Nothing enabled
    digit_en = 4'h0;
    run_to(3 * P);

    // Randomized inputs with occasional reset pulses
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) data = 16'($urandom);
      if ($urandom_range(0, 15) == 0) dp = 4'($urandom);
      if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 15) == 0) lz_blank = 1'($urandom);
      if ($urandom_range(0, 15) == 0) brightness = 4'($urandom);
      if ($urandom_range(0, 3) == 0) data[15:8] = 8'h00;
      if ($urandom_range(0, 499) == 0) do_reset();
      else step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
